avl_arbiter: RTL

AVL_ARBITER -- requirements
Module: avl_arbiter

---
 rtl/avl_arbiter_pkg.sv | 16 +
 rtl/avl_arbiter_if.sv | 45 ++++
 rtl/avl_arb_prio.sv | 31 +++
 rtl/avl_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/avl_arbiter_pkg.sv
// Shared types for the two-agent Avalon-MM arbiter: bus word, byte-enable nibble
// and the owner encoding visible on the owner port.
package avl_arbiter_pkg;

    typedef logic [31:0] word_t;
    typedef logic [3:0]  nibble_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_INSN = 2'b01,
        OWN_DATA = 2'b10
    } owner_e;

    localparam nibble_t BE_ALL = 4'b1111;

endpackage

// File: rtl/avl_arbiter_if.sv
// Bundle of the instruction agent, data agent and shared host Avalon-MM signals.
// slave is the arbiter's view; master is the surrounding agents and host.
interface avl_arbiter_if;
    import avl_arbiter_pkg::*;

    word_t   i_address;
    logic    i_read;
    word_t   i_readdata;
    logic    i_waitrequest;

    word_t   d_address;
    logic    d_read;
    logic    d_write;
    word_t   d_writedata;
    nibble_t d_byteenable;
    word_t   d_readdata;
    logic    d_waitrequest;

    word_t   m_address;
    logic    m_read;
    logic    m_write;
    word_t   m_writedata;
    nibble_t m_byteenable;
    word_t   m_readdata;
    logic    m_waitrequest;

    modport slave (
        input  i_address, i_read,
        output i_readdata, i_waitrequest,
        input  d_address, d_read, d_write, d_writedata, d_byteenable,
        output d_readdata, d_waitrequest,
        output m_address, m_read, m_write, m_writedata, m_byteenable,
        input  m_readdata, m_waitrequest
    );

    modport master (
        output i_address, i_read,
        input  i_readdata, i_waitrequest,
        output d_address, d_read, d_write, d_writedata, d_byteenable,
        input  d_readdata, d_waitrequest,
        input  m_address, m_read, m_write, m_writedata, m_byteenable,
        output m_readdata, m_waitrequest
    );

endinterface

// File: rtl/avl_arb_prio.sv
// Priority decision: data normally wins, but after STARVE_LIMIT consecutive data
// grants with insn waiting, insn is forced through.
module avl_arb_prio #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic grant_i,
    input  logic grant_d,
    output logic insn_wins
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && i_req && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    assign insn_wins = i_req && (!d_req || starve_cnt == LIMIT);

endmodule

// File: rtl/avl_arbiter.sv
// Two-agent Avalon-MM arbiter onto one host port; one transfer outstanding,
// host-side request signals are registered at grant time.
module avl_arbiter
    import avl_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    avl_arbiter_if.slave  bus,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY_I = 2'b01,
        BUSY_D = 2'b10
    } state_e;

    state_e state, state_nxt;
    logic   i_req, d_req, insn_wins, grant_i, grant_d, done;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;
    assign done  = (state != IDLE) && !bus.m_waitrequest;

    avl_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .d_req     (d_req),
        .grant_i   (grant_i),
        .grant_d   (grant_d),
        .insn_wins (insn_wins)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (insn_wins) begin
                    state_nxt = BUSY_I;
                    grant_i   = 1'b1;
                end else if (d_req) begin
                    state_nxt = BUSY_D;
                    grant_d   = 1'b1;
                end
            end
            BUSY_I, BUSY_D: if (!bus.m_waitrequest) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        owner             = OWN_NONE;
        bus.i_waitrequest = 1'b1;
        bus.d_waitrequest = 1'b1;
        case (state)
            BUSY_I: begin
                owner             = OWN_INSN;
                bus.i_waitrequest = bus.m_waitrequest;
            end
            BUSY_D: begin
                owner             = OWN_DATA;
                bus.d_waitrequest = bus.m_waitrequest;
            end
            default: ;
        endcase
    end

    assign bus.i_readdata = bus.m_readdata;
    assign bus.d_readdata = bus.m_readdata;

    // Writedata is left untouched on insn grants so it keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.m_address    <= '0;
            bus.m_read       <= 1'b0;
            bus.m_write      <= 1'b0;
            bus.m_writedata  <= '0;
            bus.m_byteenable <= '0;
        end else if (grant_i) begin
            bus.m_address    <= bus.i_address;
            bus.m_read       <= 1'b1;
            bus.m_write      <= 1'b0;
            bus.m_byteenable <= BE_ALL;
        end else if (grant_d) begin
            bus.m_address    <= bus.d_address;
            bus.m_read       <= bus.d_read & ~bus.d_write;
            bus.m_write      <= bus.d_write;
            bus.m_writedata  <= bus.d_writedata;
            bus.m_byteenable <= bus.d_byteenable;
        end else if (done) begin
            bus.m_read  <= 1'b0;
            bus.m_write <= 1'b0;
        end
    end

endmodule
